// File: rtl/aes_display_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_display_pkg                                                          |
// | Shared widths, sequencer state encoding and reference AES blocks for     |
// | the AES byte display path.                                               |
// | Ports: none (package).                                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package aes_display_pkg;

  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;
  localparam int BCD_W   = 12;
  localparam int IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } seq_state_e;

  // FIPS-197 AES-128 example ciphertext and a digit-sweep block.
  localparam logic [BLOCK_W-1:0] TV_AES128_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [BLOCK_W-1:0] TV_DIGIT_SWEEP = 128'h00112233445566778899aabbccddeeff;

endpackage
`default_nettype wire

// File: rtl/aes_byte_display_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_byte_display_sequencer_if                                            |
// | Block handshake and BCD display bundle of the byte display sequencer.    |
// | master: drives blk_valid/blk_data/blk_expected, observes the rest.       |
// | slave : the sequencer; drives blk_ready, bcd_out, bcd_valid, byte_idx,   |
// |         is_equal and busy.                                               |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface aes_byte_display_sequencer_if;
  import aes_display_pkg::*;

  logic               blk_valid;
  logic               blk_ready;
  logic [BLOCK_W-1:0] blk_data;
  logic [BLOCK_W-1:0] blk_expected;
  logic [BCD_W-1:0]   bcd_out;
  logic               bcd_valid;
  logic [IDX_W-1:0]   byte_idx;
  logic               is_equal;
  logic               busy;

  modport master (
    output blk_valid, blk_data, blk_expected,
    input  blk_ready, bcd_out, bcd_valid, byte_idx, is_equal, busy
  );

  modport slave (
    input  blk_valid, blk_data, blk_expected,
    output blk_ready, bcd_out, bcd_valid, byte_idx, is_equal, busy
  );

endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin2bcd_seq                                                              |
// | Iterative double-dabble binary to BCD converter, one bit per cycle.      |
// | Ports: clk, reset (sync, active-low), start (loads bin), bin (value),    |
// |        done (one-cycle pulse, BITS+1 cycles after the start cycle),      |
// |        bcd (result, stable while done is high), busy (converting).       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module bin2bcd_seq #(
  parameter  int BITS     = 8,
  localparam int DIGITS   = (BITS + 2) / 3,
  localparam int BCD_BITS = 4 * DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [BITS-1:0]     bin,
  output logic                done,
  output logic [BCD_BITS-1:0] bcd,
  output logic                busy
);

  localparam int              CNT_W     = $clog2(BITS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BITS - 1);

  logic [BITS-1:0]          bin_q;
  logic [BCD_BITS-1:0]      bcd_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     busy_q;
  logic                     done_q;
  logic [BCD_BITS-1:0]      adj_d;
  logic [BCD_BITS+BITS-1:0] dabble_d;

  // Correct every digit that would overflow past 9 on the next doubling,
  // then shift the binary MSB into the BCD scratch.
  always_comb begin
    adj_d = bcd_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        adj_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
    end
    dabble_d = {adj_d, bin_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bin_q  <= bin;
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        bcd_q <= dabble_d[BITS +: BCD_BITS];
        bin_q <= dabble_d[BITS-1:0];
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/aes_byte_display_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_byte_display_sequencer                                               |
// | Accepts a 128-bit AES result block, registers a compare against the      |
// | expected block and shows every byte, MSB first, as 3-digit BCD for       |
// | DWELL cycles each.                                                       |
// | Ports: clk, reset (sync, active-low), bus (slave modport: blk_valid,     |
// |        blk_ready, blk_data, blk_expected, bcd_out, bcd_valid, byte_idx,  |
// |        is_equal, busy). All outputs are registers.                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module aes_byte_display_sequencer #(
  parameter int BITS   = 8,
  parameter int DWELL  = 50000000,
  parameter int NBYTES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  aes_byte_display_sequencer_if.slave bus
);
  import aes_display_pkg::*;

  generate
    if (DWELL < 1) begin : g_dwell_check
      $error("aes_byte_display_sequencer: DWELL must be at least 1");
    end
    if ((BITS != BYTE_W) || (NBYTES * BITS != BLOCK_W)) begin : g_geom_check
      $error("aes_byte_display_sequencer: BITS/NBYTES must tile the 128-bit block in bytes");
    end
  endgenerate

  localparam int               DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NBYTES - 1);
  localparam int               REST_W     = BLOCK_W - BITS;

  seq_state_e         state_q;
  logic [REST_W-1:0]  rest_q;       // bytes still to be shown, next one at the top
  logic [DW_W-1:0]    dwell_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               bcd_valid_q;
  logic [IDX_W-1:0]   idx_q;
  logic               is_equal_q;
  logic               busy_q;
  logic               ready_q;

  logic               accept_d;
  logic               next_byte_d;
  logic               conv_start_d;
  logic [BITS-1:0]    conv_bin_d;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;
  logic               conv_busy;

  assign accept_d    = bus.blk_valid && ready_q && (state_q == IDLE);
  assign next_byte_d = (state_q == SHOW) && (dwell_q == DWELL_LAST) && (idx_q != '0);

  // The converter loads on the edge that enters CONV, so its done pulse lines
  // up with the last CONV cycle and bcd_out updates BITS+1 edges later.
  assign conv_start_d = (accept_d || next_byte_d) && !conv_busy;
  assign conv_bin_d   = accept_d ? bus.blk_data[BLOCK_W-1 -: BITS] : rest_q[REST_W-1 -: BITS];

  bin2bcd_seq #(
    .BITS (BITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start_d),
    .bin   (conv_bin_d),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .busy  (conv_busy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      rest_q      <= '0;
      dwell_q     <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      idx_q       <= '0;
      is_equal_q  <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept_d) begin
            rest_q     <= bus.blk_data[REST_W-1:0];
            is_equal_q <= (bus.blk_data == bus.blk_expected);
            idx_q      <= LAST_IDX;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          if (conv_done) begin
            bcd_q       <= conv_bcd;
            bcd_valid_q <= 1'b1;
            dwell_q     <= '0;
            state_q     <= SHOW;
          end
        end
        SHOW: begin
          if (dwell_q == DWELL_LAST) begin
            if (idx_q == '0) begin
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q   <= idx_q - IDX_W'(1);
              rest_q  <= rest_q << BITS;
              state_q <= CONV;
            end
          end else begin
            dwell_q <= dwell_q + DW_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.blk_ready = ready_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.byte_idx  = idx_q;
  assign bus.is_equal  = is_equal_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire
